// File: rtl/wots_chain_seq_pkg.sv
// Shared definitions for the WOTS multi-chain sequencer:
// ADRS word offsets, mode encodings, FSM states.
package wots_pkg;

  localparam int CHAIN_WORD = 5;
  localparam int HASH_WORD  = 6;

  localparam logic [1:0] MODE_KEYGEN = 2'd0;
  localparam logic [1:0] MODE_SIGN   = 2'd1;
  localparam logic [1:0] MODE_VERIFY = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HASH,
    S_WAIT,
    S_OUT,
    S_FIN
  } state_t;

  // ADRS is 8 big-endian words: word i is [255-32*i -: 32]
  function automatic logic [255:0] adrs_set(
    input logic [255:0] base,
    input logic [31:0]  chain,
    input logic [31:0]  step
  );
    logic [255:0] a;
    a = base;
    a[255-32*CHAIN_WORD -: 32] = chain;
    a[255-32*HASH_WORD -: 32]  = step;
    return a;
  endfunction

endpackage

// File: rtl/wots_chain_seq_if.sv
// Stream, hash-core and status signals of the WOTS chain sequencer.
// master = environment side, slave = sequencer side.
interface wots_chain_seq_if #(
  parameter int KEY_LEN = 256,
  parameter int LOG_W   = 4,
  parameter int IDX_W   = 7
);
  logic               start;
  logic [1:0]         mode;
  logic [KEY_LEN-1:0] input_key;
  logic [255:0]       hash_addr;
  logic               in_valid;
  logic               in_ready;
  logic [KEY_LEN-1:0] in_data;
  logic [LOG_W-1:0]   in_digit;
  logic               f_start;
  logic [KEY_LEN-1:0] f_data;
  logic [KEY_LEN-1:0] f_key;
  logic [255:0]       f_addr;
  logic               f_done;
  logic [KEY_LEN-1:0] f_out;
  logic               out_valid;
  logic               out_ready;
  logic [KEY_LEN-1:0] out_data;
  logic [IDX_W-1:0]   out_idx;
  logic [255:0]       hash_addr_updated;
  logic               busy;
  logic               done;

  modport master (
    output start, mode, input_key, hash_addr,
    output in_valid, in_data, in_digit,
    output f_done, f_out, out_ready,
    input  in_ready, f_start, f_data, f_key, f_addr,
    input  out_valid, out_data, out_idx,
    input  hash_addr_updated, busy, done
  );

  modport slave (
    input  start, mode, input_key, hash_addr,
    input  in_valid, in_data, in_digit,
    input  f_done, f_out, out_ready,
    output in_ready, f_start, f_data, f_key, f_addr,
    output out_valid, out_data, out_idx,
    output hash_addr_updated, busy, done
  );

endinterface

// File: rtl/wots_step_window.sv
// Maps operation mode and base-w digit to the chain step window [s, e).
// Reserved mode yields an empty window.
module wots_step_window
  import wots_pkg::*;
#(
  parameter int WOTS_W = 16,
  parameter int LOG_W  = 4
) (
  input  logic [1:0]       i_mode,
  input  logic [LOG_W-1:0] i_digit,
  output logic [LOG_W-1:0] o_s,
  output logic [LOG_W-1:0] o_e,
  output logic             o_zero
);

  localparam logic [LOG_W-1:0] LAST = LOG_W'(WOTS_W - 1);

  always_comb begin
    o_s = '0;
    o_e = '0;
    unique case (1'b1)
      (i_mode == MODE_KEYGEN): o_e = LAST;
      (i_mode == MODE_SIGN):   o_e = i_digit;
      (i_mode == MODE_VERIFY): begin
        o_s = i_digit;
        o_e = LAST;
      end
      default: ;
    endcase
  end

  assign o_zero = (o_s == o_e);

endmodule

// File: rtl/wots_chain_seq.sv
// Runs all WOTS_LEN Winternitz chains of one operation through a
// single shared F-hash core, one chain in and one result out at a time.
module wots_chain_seq
  import wots_pkg::*;
#(
  parameter int WOTS_W   = 16,
  parameter int LOG_W    = 4,
  parameter int WOTS_LEN = 67,
  parameter int KEY_LEN  = 256,
  parameter int IDX_W    = 7
) (
  input logic            clk,
  input logic            reset,
  wots_chain_seq_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WOTS_LEN - 1);

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_mode;
  logic [KEY_LEN-1:0] r_data;
  logic [LOG_W-1:0]   r_step;
  logic [LOG_W-1:0]   r_end;
  logic [IDX_W-1:0]   r_idx;
  logic [255:0]       r_faddr;
  logic [255:0]       r_hupd;

  logic [LOG_W-1:0]   w_s;
  logic [LOG_W-1:0]   w_e;
  logic               w_zero;
  logic [LOG_W-1:0]   w_step1;

  wots_step_window #(
    .WOTS_W (WOTS_W),
    .LOG_W  (LOG_W)
  ) u_win (
    .i_mode  (r_mode),
    .i_digit (bus.in_digit),
    .o_s     (w_s),
    .o_e     (w_e),
    .o_zero  (w_zero)
  );

  assign w_step1 = r_step + LOG_W'(1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.start && bus.mode != MODE_RSVD)
          w_next = S_LOAD;
      S_LOAD:
        if (bus.in_valid)
          w_next = w_zero ? S_OUT : S_HASH;
      S_HASH:
        w_next = S_WAIT;
      S_WAIT:
        if (bus.f_done)
          w_next = (w_step1 == r_end) ? S_OUT : S_HASH;
      S_OUT:
        if (bus.out_ready)
          w_next = (r_idx == LAST_IDX) ? S_FIN : S_LOAD;
      S_FIN:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_KEYGEN;
      r_data  <= '0;
      r_step  <= '0;
      r_end   <= '0;
      r_idx   <= '0;
      r_faddr <= '0;
      r_hupd  <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE:
          if (w_next == S_LOAD) begin
            r_mode <= bus.mode;
            r_idx  <= '0;
          end
        S_LOAD:
          if (bus.in_valid) begin
            r_data <= bus.in_data;
            r_step <= w_s;
            r_end  <= w_e;
            if (!w_zero)
              r_faddr <= adrs_set(bus.hash_addr,
                                  32'(r_idx), 32'(w_s));
          end
        S_WAIT:
          if (bus.f_done) begin
            r_data <= bus.f_out;
            r_step <= w_step1;
            if (w_next == S_HASH)
              r_faddr <= adrs_set(bus.hash_addr,
                                  32'(r_idx), 32'(w_step1));
          end
        S_OUT:
          if (bus.out_ready && w_next == S_LOAD)
            r_idx <= r_idx + IDX_W'(1);
        // r_faddr still holds the ADRS of the final F call
        S_FIN:
          r_hupd <= r_faddr;
        default: ;
      endcase
    end
  end

  assign bus.in_ready          = (r_state == S_LOAD);
  assign bus.f_start           = (r_state == S_HASH);
  assign bus.f_data            = r_data;
  assign bus.f_key             = bus.input_key;
  assign bus.f_addr            = r_faddr;
  assign bus.out_valid         = (r_state == S_OUT);
  assign bus.out_data          = r_data;
  assign bus.out_idx           = r_idx;
  assign bus.hash_addr_updated = r_hupd;
  assign bus.busy              = (r_state != S_IDLE) &&
                                 (r_state != S_FIN);
  assign bus.done              = (r_state == S_FIN);

endmodule
